aes_inv_cipher_ctrl: RTL and testbench
======================================

# aes_inv_cipher_ctrl

Iterative AES-128 inverse-cipher engine: one decryption round per clock, sequencing the shared combinational inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) over a single 128-bit state register. It sits between the SPI-side block buffer and the round-key store. It takes one ciphertext block per valid/ready handshake, fetches round keys by index, and returns the plaintext block on a valid/ready output.

## Interface
- No parameters; AES-128 only: 10 rounds, round keys 0..10.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  ciphertext block on in_data is valid.
- in_ready  out  1  block can accept input; high only in IDLE.
- in_data  in  128  ciphertext; byte 0 = [127:120]; column c = bits [127-32c -: 32], row 0 in the top byte.
- rk_idx  out  4  round-key index requested (0..10).
- rk_data  in  128  round key for rk_idx, supplied combinationally in the same cycle.
- out_valid  out  1  plaintext on out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  128  plaintext; same byte order as in_data; driven directly from the state register.
- busy  out  1  high in ROUND or FINAL.

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. Reset state is IDLE.
- Outputs under reset: in_ready=1, out_valid=0, busy=0, out_data=0, rk_idx=10. The state register and 4-bit round counter rnd both reset to 0.
- IDLE:
  - rk_idx=10.
  - On in_valid&in_ready: state <= in_data ^ rk_data; rnd <= 9; go to ROUND.
- ROUND:
  - rk_idx=rnd.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data).
  - If rnd==1, go to FINAL. Otherwise rnd <= rnd-1.
- FINAL:
  - rk_idx=0.
  - state <= InvSubBytes(InvShiftRows(state)) ^ rk_data.
  - Go to DONE.
- DONE:
  - out_valid=1; state and out_data are held stable. rk_idx=0.
  - On out_ready, go to IDLE. out_data keeps the last plaintext until the next accept.
- InvShiftRows rotates row r right by r positions, across columns.
- InvSubBytes is 16 parallel inverse S-box lookups.
- InvMixColumns uses the existing combinational InvMixColumns module, one instance with the full 128-bit state.
- All XORs are bitwise and 128-bit wide. There is no carry or width growth.
- in_valid outside IDLE is ignored; in_ready=0 there. Upstream must hold in_data until it is accepted.
- Simultaneous out_ready in DONE and in_valid: the output handshake completes and the FSM moves to IDLE. The new block is accepted no earlier than the next cycle; there is no same-cycle pass-through.
- rk_data is sampled every cycle in IDLE, ROUND and FINAL. The key store must not change contents while busy=1; the block does not check this.
- rst asserted mid-operation: the block enters IDLE immediately (asynchronously) and the in-flight block is discarded. No out_valid is produced for it.

## Timing
- Accept at edge E0 (end of cycle T).
- Rounds 9..1 occupy cycles T+1..T+9. FINAL occupies cycle T+10.
- out_valid rises in cycle T+11. Latency from accept to out_valid is 11 cycles.
- Output handshake at cycle D means in_ready=1 from D+1. Minimum initiation interval is 12 cycles.
- rk_idx is a pure function of FSM state and rnd: 10, 9, 8, …, 1, 0.
- out_valid, in_ready and busy are decoded from registered state only, with no combinational path from any input.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f via a bench round-key model; in_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: out_valid exactly 11 cycles after the accept, out_data=00112233445566778899aabbccddeeff.
  - rk_idx sequence 10,9,…,1,0 on consecutive cycles starting at the accept cycle.
- Output backpressure:
  - Stimulus: out_ready held low 20 cycles after out_valid.
  - Response: out_valid and out_data stay stable, in_ready=0 throughout, and a second in_valid is ignored.
  - Then pulse out_ready: in_ready=1 on the next cycle.
- Back-to-back blocks:
  - Stimulus: two C.1 ciphertexts with in_valid held high and out_ready tied high.
  - Response: two correct plaintexts whose out_valid pulses are 12 cycles apart.
- Reset mid-operation:
  - Stimulus: assert rst during cycle T+5.
  - Response: same cycle, in_ready=1, busy=0, out_valid=0, out_data=0, rk_idx=10.
  - A fresh block after reset decrypts correctly.
- All-zero key and ciphertext:
  - Stimulus: ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e with zero key.
  - Response: out_data=00000000000000000000000000000000.
- Reset values:
  - Stimulus: hold rst high with random inputs.
  - Response: every output at its reset value and no handshakes occur.

Source files
------------

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl -- iterative AES-128 inverse cipher, one round per clock.
//
// A single 128-bit state register is walked through the shared combinational
// inverse-round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey
// (-> InvMixColumns for rounds 9..1). Round keys are fetched by index from an
// external key store that answers combinationally in the same cycle.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   ciphertext on in_data is valid
//   in_ready   block accepts input (IDLE only)
//   in_data    128-bit ciphertext, byte 0 = [127:120], column-major
//   rk_idx     round-key index requested (10 .. 0)
//   rk_data    round key for rk_idx, same cycle
//   out_valid  plaintext on out_data is valid (DONE)
//   out_ready  consumer accepts out_data
//   out_data   plaintext, driven straight from the state register
//   busy       high while rounds are being computed (ROUND, FINAL)

// Combinational InvMixColumns over the full 128-bit state.
//   din   state before the column mix
//   dout  state after the column mix
module aes_inv_mix_columns (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (9, 11, 13 or 14 here), built
  // from repeated doubling so no general multiplier is needed.
  function automatic logic [7:0] mul_k(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? a  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mul_k(a0, 4'd14) ^ mul_k(a1, 4'd11) ^ mul_k(a2, 4'd13) ^ mul_k(a3, 4'd9),
            mul_k(a0, 4'd9)  ^ mul_k(a1, 4'd14) ^ mul_k(a2, 4'd11) ^ mul_k(a3, 4'd13),
            mul_k(a0, 4'd13) ^ mul_k(a1, 4'd9)  ^ mul_k(a2, 4'd14) ^ mul_k(a3, 4'd11),
            mul_k(a0, 4'd11) ^ mul_k(a1, 4'd13) ^ mul_k(a2, 4'd9)  ^ mul_k(a3, 4'd14)};
  endfunction

  assign dout = {imc_col(din[127:96]), imc_col(din[95:64]),
                 imc_col(din[63:32]),  imc_col(din[31:0])};

endmodule

// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a ciphertext; in_ready=1, rk_idx=10
// ROUND  | inverse rounds 9..1, rk_idx=rnd, with InvMixColumns
// FINAL  | last round, rk_idx=0, no InvMixColumns
// DONE   | plaintext held on out_data with out_valid=1 until out_ready
module aes_inv_cipher_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  fsm_t         st, st_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [127:0] state_q, state_nxt;
  logic [127:0] ark;
  logic [127:0] imc;

  // GF(2^8) arithmetic for the inverse S-box. The S-box is computed
  // (multiplicative inverse after the inverse affine map) rather than
  // stored as a 256-entry table.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 for nonzero x, and 0 maps to 0 for free.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gmul(gmul(x, x), x);
    x7   = gmul(gmul(x3, x3), x);
    x15  = gmul(gmul(x7, x7), x);
    x31  = gmul(gmul(x15, x15), x);
    x63  = gmul(gmul(x31, x31), x);
    x127 = gmul(gmul(x63, x63), x);
    return gmul(x127, x127);
  endfunction

  // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05, then field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  // Byte (row r, column c) sits at index 4c+r; row r moves right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  // Shared round datapath; ROUND takes imc, FINAL takes ark directly.
  assign ark = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_data;

  aes_inv_mix_columns u_imc (
    .din  (ark),
    .dout (imc)
  );

  assign out_data = state_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      rnd     <= 4'd0;
      state_q <= '0;
    end else begin
      st      <= st_nxt;
      rnd     <= rnd_nxt;
      state_q <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    st_nxt    = st;
    rnd_nxt   = rnd;
    state_nxt = state_q;
    case (st)
      IDLE: begin
        if (in_valid) begin
          state_nxt = in_data ^ rk_data;
          rnd_nxt   = 4'd9;
          st_nxt    = ROUND;
        end
      end
      ROUND: begin
        state_nxt = imc;
        if (rnd == 4'd1) st_nxt = FINAL;
        else             rnd_nxt = rnd - 4'd1;
      end
      FINAL: begin
        state_nxt = ark;
        st_nxt    = DONE;
      end
      DONE: begin
        if (out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Outputs, decoded from registered state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = 4'd0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = 4'd10;
      end
      ROUND: begin
        busy   = 1'b1;
        rk_idx = rnd;
      end
      FINAL: begin
        busy   = 1'b1;
        rk_idx = 4'd0;
      end
      DONE: begin
        out_valid = 1'b1;
        rk_idx    = 4'd0;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Self-checking bench for aes_inv_cipher_ctrl. A byte-array AES reference
// (S-box built by brute-force field inversion, key expansion, textbook
// inverse cipher) produces every expected plaintext; the bench also acts as
// the round-key store.
module tb_aes_inv_cipher_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk_mem [11];

  always #5 clk = ~clk;

  aes_inv_cipher_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always_comb begin
    rk_data = '0;
    if (int'(rk_idx) < 11) rk_data = rk_mem[int'(rk_idx)];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk_mem[10][127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*((c+row)%4)+row] = s[4*c+row];
      for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ rk_mem[r][127-8*i -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
          s[4*c+1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
          s[4*c+2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
          s[4*c+3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus tasks ----------------
  // Called at a negedge with the DUT in IDLE. hold = cycles of backpressure.
  task automatic run_block(input string tag, input logic [127:0] ct,
                           input logic [127:0] exp, input int hold);
    int lat;
    in_valid  = 1'b1;
    in_data   = ct;
    out_ready = 1'b0;
    #1;
    chk({tag, "_acc_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_acc_rk"}, 128'(rk_idx), 128'(10));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rnd128();
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk($sformatf("%s_rk_c%0d", tag, lat), 128'(rk_idx), 128'((lat <= 10) ? 10 - lat : 0));
      chk($sformatf("%s_busy_c%0d", tag, lat), 128'(busy), 128'(1));
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(11));
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_done_rk"}, 128'(rk_idx), 128'(0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = rnd128();
      @(negedge clk);
      chk($sformatf("%s_hold_valid%0d", tag, i), 128'(out_valid), 128'(1));
      chk($sformatf("%s_hold_data%0d", tag, i), out_data, exp);
      chk($sformatf("%s_hold_ready%0d", tag, i), 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_post_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_post_busy"}, 128'(busy), 128'(0));
    chk({tag, "_post_data"}, out_data, exp);
  endtask

  task automatic back_to_back(input logic [127:0] ct, input logic [127:0] exp);
    int pulses = 0;
    int first  = 0;
    int cyc    = 0;
    in_valid  = 1'b1;
    in_data   = ct;
    out_ready = 1'b1;
    while (pulses < 2 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk($sformatf("b2b_data%0d", pulses), out_data, exp);
        if (pulses == 0) first = cyc;
        else chk("b2b_gap", 128'(cyc - first), 128'(12));
        pulses++;
        if (pulses == 2) in_valid = 1'b0;
      end
    end
    chk("b2b_pulses", 128'(pulses), 128'(2));
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", 128'(in_ready), 128'(1));
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_out_data"}, out_data, 128'(0));
    chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(10));
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] key, ct;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    build_sbox();

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      reset_outputs($sformatf("rst_hold%0d", i));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = rnd128();
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    chk("rel_busy", 128'(busy), 128'(0));
    chk("rel_ready", 128'(in_ready), 128'(1));

    // FIPS-197 C.1, checked against the published plaintext
    load_key(C1_KEY);
    run_block("c1", C1_CT, C1_PT, 0);

    // Backpressure: 20 cycles with a second in_valid offered and ignored
    run_block("bp", C1_CT, C1_PT, 20);

    // Back-to-back with in_valid and out_ready held high
    back_to_back(C1_CT, C1_PT);

    // Reset mid-operation during cycle T+5
    in_valid = 1'b1;
    in_data  = C1_CT;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_before", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_block("after_rst", C1_CT, C1_PT, 0);

    // All-zero key
    load_key(128'h0);
    run_block("zero", Z_CT, 128'h0, 1);

    // Random keys and ciphertexts against the reference model
    for (int n = 0; n < 6; n++) begin
      key = rnd128();
      ct  = rnd128();
      load_key(key);
      run_block($sformatf("rand%0d", n), ct, ref_decrypt(ct), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
